uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx_frame.sv | 126 ++++++++++++
 tb/tb_uart_tx_frame.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic IdleLevel = 1'b1;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: free-running 0..CLKS_PER_BIT-1 counter, restartable by clear.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_tick = (cnt_q == CntMax);
    cnt_d    = cnt_q + CntW'(1);
    if (clear || bit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Single-frame UART transmitter launched by a rising edge on the debounced button level.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] data,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned BitCntW    = $clog2(DATA_BITS);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 txd_q, txd_d;
  logic                 transmit_q;
  logic                 launch;
  logic                 bit_tick;

  assign launch = transmit & ~transmit_q & (state_q == StIdle);

  uart_baud_gen #(
    .CLKS_PER_BIT(ClksPerBit)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (launch),
    .bit_tick(bit_tick)
  );

  // txd_d is the line level for the bit that begins on the next clock.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    txd_d     = txd_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d   = StStart;
          shift_d   = data;
          parity_d  = (^data) ^ PARITY_ODD[0];
          bit_cnt_d = '0;
          txd_d     = 1'b0;
        end
      end
      StStart: begin
        if (bit_tick) begin
          state_d = StData;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = StParity;
              txd_d   = parity_q;
            end else begin
              state_d = StStop;
              txd_d   = IdleLevel;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          state_d = StStop;
          txd_d   = IdleLevel;
        end
      end
      StStop: begin
        if (bit_tick) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = IdleLevel;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      parity_q   <= 1'b0;
      txd_q      <= IdleLevel;
      transmit_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
      transmit_q <= transmit;
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != StIdle);
  assign done = (state_q == StStop) & bit_tick;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three parity configurations driven in parallel against a frame model.
module tb_uart_tx_frame;

  localparam int Cpb = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] txd, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Index 0: no parity, 1: even parity, 2: odd parity.
  uart_tx_frame #(
    .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)
  ) u_dut_np (
    .clk(clk), .reset(reset), .transmit(transmit), .data(data),
    .txd(txd[0]), .busy(busy[0]), .done(done[0])
  );

  uart_tx_frame #(
    .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
  ) u_dut_even (
    .clk(clk), .reset(reset), .transmit(transmit), .data(data),
    .txd(txd[1]), .busy(busy[1]), .done(done[1])
  );

  uart_tx_frame #(
    .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)
  ) u_dut_odd (
    .clk(clk), .reset(reset), .transmit(transmit), .data(data),
    .txd(txd[2]), .busy(busy[2]), .done(done[2])
  );

  // Reference model: a frame is a list of bit values, each held Cpb cycles.
  function automatic int frame_len(input int c);
    return (c != 0) ? 11 * Cpb : 10 * Cpb;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int c, input int cyc);
    int k;
    k = cyc / Cpb;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && c != 0) return (^d) ^ (c == 2);
    return 1'b1;
  endfunction

  logic       m_tq;
  logic [2:0] m_active;
  int         m_cyc [3];
  logic [7:0] m_data [3];
  logic [2:0] exp_txd, exp_busy, exp_done;
  logic [8:0] exp_v, obs_v;

  always @(posedge clk) begin
    m_tq <= reset ? 1'b1 : transmit;
    for (int c = 0; c < 3; c++) begin
      if (reset) begin
        m_active[c] <= 1'b0;
      end else if (!m_active[c]) begin
        if (transmit && !m_tq) begin
          m_active[c] <= 1'b1;
          m_cyc[c]    <= 0;
          m_data[c]   <= data;
        end
      end else if (m_cyc[c] == frame_len(c) - 1) begin
        m_active[c] <= 1'b0;
      end else begin
        m_cyc[c] <= m_cyc[c] + 1;
      end
    end
  end

  always_comb begin
    exp_txd  = 3'b111;
    exp_busy = 3'b000;
    exp_done = 3'b000;
    for (int c = 0; c < 3; c++) begin
      if (m_active[c] === 1'b1) begin
        exp_txd[c]  = frame_bit(m_data[c], c, m_cyc[c]);
        exp_busy[c] = 1'b1;
        exp_done[c] = (m_cyc[c] == frame_len(c) - 1);
      end
    end
  end

  assign exp_v = {exp_done, exp_busy, exp_txd};
  assign obs_v = {done, busy, txd};

  task automatic test_reset;
    reset = 1'b1;
    transmit = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== 9'b000_000_111) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs_v, 9'b000_000_111);
      end
    end
  endtask

  task automatic test_single_frame;
    int busy_cnt, busy1_cnt, first_busy, done_at, done_cnt;
    logic [9:0] seq;
    logic p_even, p_odd;
    busy_cnt = 0; busy1_cnt = 0; first_busy = -1; done_at = -1; done_cnt = 0;
    seq = '0; p_even = 1'bx; p_odd = 1'bx;
    data = 8'hA5;
    transmit = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL single_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (busy[0]) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = i;
      end
      if (busy[1]) busy1_cnt++;
      if (done[0]) begin
        done_cnt++;
        done_at = i;
      end
      if (i <= 100 && (i - 1) % Cpb == 5) seq[(i-1)/Cpb] = txd[0];
      if (i == 96) begin
        p_even = txd[1];
        p_odd  = txd[2];
      end
      if (i == 3) transmit = 1'b0;
    end
    n_cmp++;
    if (first_busy != 1) begin
      n_err++; $display("FAIL launch_latency got=%0d want=1", first_busy);
    end
    n_cmp++;
    if (busy_cnt != 100) begin
      n_err++; $display("FAIL busy_width got=%0d want=100", busy_cnt);
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 100) begin
      n_err++; $display("FAIL done_pulse got_cnt=%0d got_at=%0d want=1@100", done_cnt, done_at);
    end
    n_cmp++;
    if (seq !== 10'b11_0100_1010) begin
      n_err++; $display("FAIL a5_bits got=%b want=%b", seq, 10'b11_0100_1010);
    end
    n_cmp++;
    if (p_even !== 1'b0 || p_odd !== 1'b1) begin
      n_err++; $display("FAIL a5_parity got=%b%b want=01", p_even, p_odd);
    end
    n_cmp++;
    if (busy1_cnt != 110) begin
      n_err++; $display("FAIL parity_len got=%0d want=110", busy1_cnt);
    end
  endtask

  task automatic test_held;
    int launches_a, launches_b;
    logic prev;
    launches_a = 0; launches_b = 0; prev = 1'b0;
    data = 8'h3C;
    transmit = 1'b1;
    for (int i = 1; i <= 655; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL held_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (busy[0] && !prev) begin
        if (i <= 500) launches_a++;
        else launches_b++;
      end
      prev = busy[0];
      if (i == 30) data = 8'($urandom);
      if (i == 500) transmit = 1'b0;
      if (i == 505) transmit = 1'b1;
    end
    n_cmp++;
    if (launches_a != 1) begin
      n_err++; $display("FAIL held_single got=%0d want=1", launches_a);
    end
    n_cmp++;
    if (launches_b != 1) begin
      n_err++; $display("FAIL repress got=%0d want=1", launches_b);
    end
  endtask

  task automatic test_retrigger;
    int launches, last_busy;
    logic prev;
    launches = 0; last_busy = -1; prev = 1'b0;
    transmit = 1'b0;
    repeat (2) @(negedge clk);
    data = 8'($urandom);
    transmit = 1'b1;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL retrig_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (busy[0] && !prev) launches++;
      if (busy[0]) last_busy = i;
      prev = busy[0];
      if (i == 3 || i == 43) transmit = 1'b0;
      if (i == 40) transmit = 1'b1;
    end
    n_cmp++;
    if (launches != 1 || last_busy != 100) begin
      n_err++;
      $display("FAIL retrigger_ignored got_launches=%0d got_last=%0d want=1@100", launches,
               last_busy);
    end
  endtask

  task automatic test_parity;
    logic p_even, p_odd;
    int len1, len2;
    p_even = 1'bx; p_odd = 1'bx; len1 = 0; len2 = 0;
    data = 8'h07;
    transmit = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL parity_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (busy[1]) len1++;
      if (busy[2]) len2++;
      if (i == 96) begin
        p_even = txd[1];
        p_odd  = txd[2];
      end
      if (i == 2) transmit = 1'b0;
    end
    n_cmp++;
    if (p_even !== 1'b1 || p_odd !== 1'b0) begin
      n_err++; $display("FAIL h07_parity got=%b%b want=10", p_even, p_odd);
    end
    n_cmp++;
    if (len1 != 110 || len2 != 110) begin
      n_err++; $display("FAIL h07_len got=%0d/%0d want=110/110", len1, len2);
    end
  endtask

  task automatic test_reset_mid;
    int dones, busy_after;
    dones = 0; busy_after = 0;
    data = 8'($urandom);
    transmit = 1'b1;
    for (int i = 1; i <= 210; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL rstmid_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (done !== 3'b000) dones++;
      if (i > 56 && busy !== 3'b000) busy_after++;
      if (i == 56) begin
        n_cmp++;
        if (txd !== 3'b111 || busy !== 3'b000) begin
          n_err++; $display("FAIL rst_truncate got_txd=%b got_busy=%b want=111/000", txd, busy);
        end
      end
      if (i == 55) reset = 1'b1;
      if (i == 58) reset = 1'b0;
    end
    n_cmp++;
    if (dones != 0 || busy_after != 0) begin
      n_err++; $display("FAIL rst_no_done_no_launch got=%0d/%0d want=0/0", dones, busy_after);
    end
    transmit = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL random_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0) transmit = ~transmit;
      if ($urandom_range(0, 9) == 0) data = 8'($urandom);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_held();
    test_retrigger();
    test_parity();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
